cic_interpolator: RTL and testbench
===================================

# cic_interpolator

Pipelined N-stage CIC interpolator for the TX/tuning path: it accepts one signed sample every R clk cycles through a valid/ready handshake and produces one filtered sample per clk cycle. It is the upsampling counterpart of the CIC decimator on the RX path and shares that block's width-growth conventions. Comb stages run on a single-cycle enable at the low rate, followed by zero-stuffing and integrator stages at the full clk rate. Everything is in the single clk domain; there are no derived clocks.

## Interface
- N, 2, number of comb stages and number of integrator stages (N ≥ 1)
- R, 16, interpolation ratio; must be a power of two, R ≥ 2
- INPUT_WIDTH, 14, signed input sample width
- OUTPUT_WIDTH, 14, signed output sample width
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, asynchronous, active-high; clock is clk
- in_data  in  INPUT_WIDTH  signed low-rate sample
- in_valid  in  1  in_data is valid
- in_ready  out  1  block takes in_data this cycle
- out_data  out  OUTPUT_WIDTH  signed full-rate filtered sample
- out_valid  out  1  out_data is meaningful; sticky once set
- underrun  out  1  sticky flag; a ready slot passed with in_valid low

## Operation
- Internal width: W = INPUT_WIDTH + N·LOG2R + 1, where LOG2R = $clog2(R). All comb and integrator arithmetic is two's complement, modulo 2^W. Integrator wrap-around is expected and is not an error.
- Phase counter: counts 0..R-1 and wraps. It is 0 in the first cycle after rst deasserts.
- in_ready = (phase == 0). A transfer happens when in_valid & in_ready.
- Transfer: the sign-extended in_data enters the comb chain.
- Underrun: if in_valid is low in a phase-0 cycle, the last accepted sample is reused (0 if none yet), and underrun is set.
- Comb chain (fires only at the phase-0 edge):
  - c0 = x
  - c_k = c_{k-1} − d_k
  - d_k <= c_{k-1}
  - The combs are combinational between the delay registers.
- Zero-stuff register: loads c_N at the phase-0 edge and is 0 in every other cycle. Its value is therefore nonzero only during phase 1.
- Integrators (every cycle, each stage registered):
  - i_0 <= i_0 + stuff
  - i_k <= i_k + i_{k-1}
- Gain is R^(N-1). Scaling uses SHIFT = (N-1)·LOG2R + INPUT_WIDTH − OUTPUT_WIDTH.
  - SHIFT > 0: out_data <= i_{N-1} >>> SHIFT (arithmetic shift).
  - SHIFT < 0: out_data <= i_{N-1} <<< −SHIFT.
  - SHIFT = 0: out_data <= i_{N-1}.
  - Truncation keeps the low OUTPUT_WIDTH bits of the shifted value. There is no rounding and no saturation.
- out_valid: set at the edge where the first transferred sample's stuff value reaches out_data. It stays high until rst.

## Timing
- Reset values: in_ready 0 while rst is high, then 1 in the first cycle after release. out_data 0, out_valid 0, underrun 0. Phase, all combs, all delays, the stuff register and all integrators are 0.
- Transfer in cycle T: stuff is valid in T+1 and i_0 updates at the end of T+1.
- i_{N-1} first reflects the sample at T+1+N. out_data first reflects it at T+2+N, and out_valid rises in that same cycle. For N=2 that is T+4.
- Throughput: one input per R cycles and one output per cycle.
- in_ready is a fixed schedule and does not depend on in_valid. No input is ever accepted outside phase 0.
- rst asserted mid-operation: all state clears immediately. After release, the first slot is again the first cycle, and no partially filtered data is ever emitted.
- Simultaneous underrun and reset: reset wins and underrun stays 0.

## Structure
- Package cic_pkg holds:
  - a width function cic_width(in_w, n, r) returning INPUT_WIDTH + N·$clog2(R) + 1;
  - the shift-computation function;
  - the power-of-two check.
- The CIC decimator uses the same package.
- Sub-module cic_integrator_stage: one registered accumulator, parameterised by W, with async reset. It is instantiated N times in a generate loop.
- Combs, phase counter, handshake and scaling stay in the top-level module.

## Test plan
- Impulse (N=2, R=4, INPUT_WIDTH=14, OUTPUT_WIDTH=16, so SHIFT=0): input 1 at the first slot, then 0 at every later slot.
  - out_data from T+4 is 1,2,3,4,3,2,1,0, then 0 thereafter.
  - out_valid rises at T+4.
- DC with default parameters: constant input 1000 → out_data settles to exactly 1000 after the transient and stays at 1000.
- Full-scale step with default parameters: input −8192 held for 200 slots → out_data settles at −8192, with no overflow artefacts despite integrator wrap-around.
- Handshake: in_valid held high continuously → exactly one transfer every 16 cycles. Drop in_valid for one slot → underrun goes to 1, and the output continues as for a held sample.
- Reset mid-stream: assert rst while the filter is at nonzero steady state. All outputs must be 0 while rst is high, with out_valid = 0. After release, re-run the impulse test and check identical results.
- Randomised check: random inputs at every slot are compared against a golden model (zero-stuff, then N-stage integrate, then comb), aligned by the T+2+N latency. The output must be bit-exact.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC helpers: internal width growth, output scaling shift and
// interpolation-ratio legality check (used by interpolator and decimator).
package cic_pkg;

    // Internal accumulator width: input width plus N*log2(R) growth plus one guard bit
    function automatic int cic_width(input int in_w, input int n, input int r);
        return in_w + n * $clog2(r) + 1;
    endfunction

    // Right-shift that removes the R^(N-1) gain and narrows to the output width
    function automatic int cic_shift(input int n, input int r, input int in_w, input int out_w);
        return (n - 1) * $clog2(r) + in_w - out_w;
    endfunction

    // True when r is a power of two and at least 2
    function automatic bit cic_is_pow2(input int r);
        return (r >= 2) && ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One full-rate CIC integrator: a registered modulo-2^W accumulator.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int W = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] i_add,
    output logic signed [W-1:0] o_acc
);

    logic signed [W-1:0] r_acc;

    // Accumulate every cycle; wrap-around is intentional and cancelled by the combs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_acc <= '0;
        else     r_acc <= r_acc + i_add;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: low-rate combs, zero-stuffing, full-rate integrators.
// One input is taken every R cycles (phase 0); one output is produced per cycle.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int N            = 2,
    parameter int R            = 16,
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           out_valid,
    output logic                           underrun
);

    localparam int LOG2R = $clog2(R);
    localparam int W     = cic_width(INPUT_WIDTH, N, R);
    localparam int SHIFT = cic_shift(N, R, INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int SH_R  = (SHIFT > 0) ? SHIFT : 0;
    localparam int SH_L  = (SHIFT < 0) ? -SHIFT : 0;

    if (!cic_is_pow2(R) || N < 1) begin : g_bad_param
        $error("cic_interpolator: R must be a power of two >= 2 and N >= 1");
    end

    // Arithmetic shift to remove the gain, then keep the low OUTPUT_WIDTH bits
    function automatic logic signed [OUTPUT_WIDTH-1:0] scale_out(input logic signed [W-1:0] v);
        logic signed [W+OUTPUT_WIDTH-1:0] t;
        t = (W + OUTPUT_WIDTH)'(v);
        t = t >>> SH_R;
        t = t <<< SH_L;
        return t[OUTPUT_WIDTH-1:0];
    endfunction

    logic [LOG2R-1:0]              r_phase;
    logic signed [INPUT_WIDTH-1:0] r_last;
    logic signed [W-1:0]           r_d [1:N];
    logic signed [W-1:0]           r_stuff_p0;
    logic [N:0]                    r_vld_p;
    logic signed [OUTPUT_WIDTH-1:0] r_out;
    logic                          r_out_valid;
    logic                          r_underrun;

    logic                          w_slot;
    logic                          w_xfer;
    logic signed [INPUT_WIDTH-1:0] w_sample;
    logic signed [W-1:0]           w_cprev [1:N];
    logic signed [W-1:0]           w_cn;
    logic signed [W-1:0]           w_int [0:N-1];

    // Phase 0 is the only input slot; held low during reset so nothing is accepted
    assign w_slot   = (r_phase == '0) && !rst;
    assign w_xfer   = w_slot && in_valid;
    assign w_sample = in_valid ? in_data : r_last;
    assign in_ready = w_slot;

    // Free-running phase counter, wraps naturally because R is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_phase <= '0;
        else     r_phase <= r_phase + 1'b1;
    end

    // Comb chain between the delay registers; w_cprev[k] is c_{k-1}
    always_comb begin
        logic signed [W-1:0] v;
        v = W'(w_sample);
        for (int k = 1; k <= N; k++) begin
            w_cprev[k] = v;
            v          = v - r_d[k];
        end
        w_cn = v;
    end

    // Low-rate state: comb delays, held sample, underrun flag, zero-stuff register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= N; k++) r_d[k] <= '0;
            r_last     <= '0;
            r_underrun <= 1'b0;
            r_stuff_p0 <= '0;
        end else begin
            if (w_slot) begin
                for (int k = 1; k <= N; k++) r_d[k] <= w_cprev[k];
                r_last <= w_sample;
                if (!in_valid) r_underrun <= 1'b1;
            end
            r_stuff_p0 <= w_slot ? w_cn : '0;
        end
    end

    // Integrator cascade, one register per stage
    for (genvar k = 0; k < N; k++) begin : g_int
        cic_integrator_stage #(.W(W)) u_int (
            .clk   (clk),
            .rst   (rst),
            .i_add ((k == 0) ? r_stuff_p0 : w_int[(k == 0) ? 0 : k-1]),
            .o_acc (w_int[k])
        );
    end

    // Track the first transfer through stuff and integrators so out_valid meets its data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p     <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_vld_p     <= {r_vld_p[N-1:0], w_xfer};
            r_out_valid <= r_out_valid | r_vld_p[N];
            r_out       <= scale_out(w_int[N-1]);
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_out_valid;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench: impulse (N=2,R=4,16-bit out), DC, full-scale step,
// handshake schedule, underrun and mid-stream reset (default parameters).
module tb_cic_interpolator;

    logic clk = 1'b0;
    logic rst;

    logic signed [13:0] da, db;
    logic               va, vb;
    logic               ready_a, ready_b;
    logic signed [15:0] out_a;
    logic signed [13:0] out_b;
    logic               ovld_a, ovld_b, und_a, und_b;

    int vectors;
    int errs;
    int cyc;

    always #5 clk = ~clk;

    cic_interpolator #(.N(2), .R(4), .INPUT_WIDTH(14), .OUTPUT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(da), .in_valid(va), .in_ready(ready_a),
        .out_data(out_a), .out_valid(ovld_a), .underrun(und_a)
    );

    cic_interpolator dut_b (
        .clk(clk), .rst(rst), .in_data(db), .in_valid(vb), .in_ready(ready_b),
        .out_data(out_b), .out_valid(ovld_b), .underrun(und_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Impulse run on dut_a starting in the current cycle (cycle 0 after release)
    task automatic run_impulse(input string tag);
        int imp [12] = '{1, 2, 3, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        da = 14'sd1;
        step();
        da = 14'sd0;
        step();
        step();
        chk({tag, "_vld_pre"}, int'(ovld_a), 0);
        step();
        chk({tag, "_vld_rise"}, int'(ovld_a), 1);
        for (int i = 0; i < 12; i++) begin
            chk({tag, "_out"}, int'(out_a), imp[i]);
            chk({tag, "_ready_a"}, int'(ready_a), (cyc % 4 == 0) ? 1 : 0);
            step();
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        cyc     = 0;
        rst     = 1'b1;
        va = 1'b0; da = '0;
        vb = 1'b0; db = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_b", int'(ready_b), 0);
        chk("rst_ready_a", int'(ready_a), 0);
        chk("rst_out_b",   int'(out_b), 0);
        chk("rst_vld_b",   int'(ovld_b), 0);
        chk("rst_und_b",   int'(und_b), 0);

        // Release reset: cycle 0 is the first input slot
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("ready_first_a", int'(ready_a), 1);
        chk("ready_first_b", int'(ready_b), 1);
        va = 1'b1;
        vb = 1'b1; db = 14'sd1000;

        // Impulse on A; DC 1000 on B in parallel
        da = 14'sd1;
        step();
        da = 14'sd0;
        step();
        step();
        chk("imp_vld_pre", int'(ovld_a), 0);
        chk("dc_vld_pre",  int'(ovld_b), 0);
        step();
        chk("imp_vld_rise", int'(ovld_a), 1);
        chk("dc_vld_rise",  int'(ovld_b), 1);
        chk("dc_first",     int'(out_b), 62);
        begin
            int imp [12] = '{1, 2, 3, 4, 3, 2, 1, 0, 0, 0, 0, 0};
            for (int i = 0; i < 12; i++) begin
                chk("imp_out", int'(out_a), imp[i]);
                if (i == 1) chk("dc_second", int'(out_b), 125);
                step();
            end
        end

        // Handshake schedule and DC settle
        while (cyc < 100) begin
            chk("ready_b", int'(ready_b), (cyc % 16 == 0) ? 1 : 0);
            chk("ready_a", int'(ready_a), (cyc % 4 == 0) ? 1 : 0);
            if (cyc >= 20) chk("dc_settle", int'(out_b), 1000);
            step();
        end
        chk("imp_tail_a", int'(out_a), 0);
        chk("und_a_none", int'(und_a), 0);
        chk("und_b_none", int'(und_b), 0);

        // Full-scale negative step held for 200 slots
        while (cyc % 16 != 0) step();
        db = -14'sd8192;
        repeat (200 * 16) step();
        for (int i = 0; i < 48; i++) begin
            chk("step_out", int'(out_b), -8192);
            step();
        end
        chk("step_vld", int'(ovld_b), 1);

        // Drop in_valid for exactly one slot
        while (cyc % 16 != 0) step();
        chk("und_before", int'(und_b), 0);
        vb = 1'b0;
        step();
        vb = 1'b1;
        chk("und_set", int'(und_b), 1);
        for (int i = 0; i < 48; i++) begin
            chk("und_hold_out", int'(out_b), -8192);
            step();
        end
        chk("und_sticky", int'(und_b), 1);
        chk("und_a_still", int'(und_a), 0);

        // Mid-stream reset with in_valid low on the reset-time slot
        rst = 1'b1;
        vb  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_out_b", int'(out_b), 0);
            chk("mid_rst_vld_b", int'(ovld_b), 0);
            chk("mid_rst_und_b", int'(und_b), 0);
            chk("mid_rst_rdy_b", int'(ready_b), 0);
            chk("mid_rst_out_a", int'(out_a), 0);
            chk("mid_rst_vld_a", int'(ovld_a), 0);
            step();
        end
        rst = 1'b0;
        cyc = 0;
        vb  = 1'b1;
        db  = 14'sd0;
        #1;
        chk("rerun_ready_a", int'(ready_a), 1);
        run_impulse("rerun");
        chk("rerun_und_b", int'(und_b), 0);
        chk("rerun_out_b", int'(out_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
